// File: rtl/ram_byte_loader.sv
`default_nettype none
// ============================================================================
// Module   : ram_byte_loader
// Purpose  : Packs a byte stream into little-endian words and writes them to
//            consecutive RAM addresses; passes the CPU RAM port through when idle.
// Revision : 1.0 - initial release
// ============================================================================
module ram_byte_loader #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 1400,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] base_addr,
   input  logic [CW-1:0]    word_count,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   input  logic [WIDTH-1:0] cpu_address,
   input  logic [WIDTH-1:0] cpu_wdata,
   input  logic             cpu_enw,
   output logic [WIDTH-1:0] ram_address,
   output logic [WIDTH-1:0] ram_wdata,
   output logic             ram_enw
);

   localparam logic [CW-1:0] CW_ONE = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] base_q, base_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic [CW-1:0]    count_q, count_d;
   logic [CW-1:0]    word_idx_q, word_idx_d;
   logic [1:0]       byte_cnt_q, byte_cnt_d;
   logic [WIDTH-1:0] loader_addr;

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      word_d     = word_q;
      count_d    = count_q;
      word_idx_d = word_idx_q;
      byte_cnt_d = byte_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d     = base_addr;
               count_d    = word_count;
               word_idx_d = '0;
               byte_cnt_d = '0;
               state_d    = (word_count == '0) ? S_DONE : S_FILL;
            end
         end
         S_FILL: begin
            if (in_valid) begin
               word_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            // count is non-zero here, so count-1 cannot underflow
            if (word_idx_q == count_q - CW_ONE) begin
               state_d = S_DONE;
            end else begin
               word_idx_d = word_idx_q + CW_ONE;
               state_d    = S_FILL;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         word_q     <= '0;
         count_q    <= '0;
         word_idx_q <= '0;
         byte_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         word_q     <= word_d;
         count_q    <= count_d;
         word_idx_q <= word_idx_d;
         byte_cnt_q <= byte_cnt_d;
      end
   end

   assign in_ready    = (state_q == S_FILL);
   assign busy        = (state_q == S_FILL) || (state_q == S_WRITE);
   assign done        = (state_q == S_DONE);
   assign loader_addr = base_q + WIDTH'(word_idx_q);

   // CPU traffic is dropped, not stalled, while the loader owns the RAM port
   assign ram_address = busy ? loader_addr : cpu_address;
   assign ram_wdata   = busy ? word_q : cpu_wdata;
   assign ram_enw     = busy ? (state_q == S_WRITE) : cpu_enw;

endmodule
`default_nettype wire
